// File: rtl/video_pkg.sv
// ----------------------------------------------------------------------------
// video_pkg
// Types shared by the video pipeline blocks: the frame-swap scheduler FSM
// state encoding and the buffer index type, which the framebuffer and the
// renderer use as well. Also holds a small sizing helper for the ce divider.
// ----------------------------------------------------------------------------
package video_pkg;

    typedef enum logic [1:0] {
        FS_START,
        FS_RENDER,
        FS_READY
    } fs_state_t;

    typedef logic buf_idx_t;

    // Counter width needed to count 0..div-1; at least one bit so that a
    // divide-by-one counter still has a legal declaration.
    function automatic int ce_cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/frame_swap_scheduler_if.sv
// ----------------------------------------------------------------------------
// frame_swap_scheduler_if
// Bundles the signals between the frame-swap scheduler and the rest of the
// video pipeline (pixel iterator, renderer, framebuffer).
//   ce           scheduler -> iterator   pixel clock enable
//   swap         iterator  -> scheduler  end-of-frame strobe (valid with ce)
//   render_start scheduler -> renderer   1-cycle go pulse
//   render_done  renderer  -> scheduler  1-cycle back-buffer-complete pulse
//   display_buf  scheduler -> scan-out   buffer being displayed
//   draw_buf     scheduler -> renderer   buffer being drawn (= ~display_buf)
//   frame_cnt    scheduler -> status     completed buffer flips (wraps)
//   dropped_cnt  scheduler -> status     repeated frames (saturates)
// Modports: master = scheduler side, slave = pipeline/environment side.
// ----------------------------------------------------------------------------
interface frame_swap_scheduler_if #(
    parameter int FRAME_CNT_WIDTH = 16,
    parameter int DROP_CNT_WIDTH  = 8
) ();
    import video_pkg::*;

    logic                       ce;
    logic                       swap;
    logic                       render_start;
    logic                       render_done;
    buf_idx_t                   display_buf;
    buf_idx_t                   draw_buf;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
    logic [DROP_CNT_WIDTH-1:0]  dropped_cnt;

    modport master (
        output ce, render_start, display_buf, draw_buf, frame_cnt, dropped_cnt,
        input  swap, render_done
    );

    modport slave (
        input  ce, render_start, display_buf, draw_buf, frame_cnt, dropped_cnt,
        output swap, render_done
    );

endinterface

// File: rtl/frame_swap_scheduler_ce_divider.sv
// ----------------------------------------------------------------------------
// ce_divider
// Generates a registered clock enable that is high for one clk_rgb cycle out
// of every DIV cycles. The counter runs 0..DIV-1; ce is asserted in the cycle
// after the counter reaches DIV-1. DIV=1 gives ce high every cycle after the
// first post-reset edge.
// Ports:
//   clk_rgb  in   pixel-domain clock
//   rst      in   synchronous active-high reset (counter and ce cleared)
//   ce       out  registered clock enable
// ----------------------------------------------------------------------------
module ce_divider
    import video_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk_rgb,
    input  logic rst,
    output logic ce
);

    localparam int             CW   = ce_cnt_width(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ce_q,  ce_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        ce_d  = (cnt_q == LAST);
    end

    always_ff @(posedge clk_rgb) begin
        if (rst) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/frame_swap_scheduler.sv
// ----------------------------------------------------------------------------
// frame_swap_scheduler
// Sequences the video pipeline: drives the pixel clock enable and runs the
// double-buffer handshake between renderer and scan-out. The renderer is
// handed the back buffer (render_start), and once it reports render_done the
// buffers are flipped on the next ce-qualified end-of-frame swap strobe, so
// scan-out never switches buffer mid-frame. If a frame ends before rendering
// completes, the displayed buffer is repeated and counted as dropped.
// Ports:
//   clk_rgb  in      sole clock
//   rst      in      synchronous active-high reset; aborts any frame in flight
//   bus      master  ce, swap, render_start, render_done, display_buf,
//                    draw_buf, frame_cnt, dropped_cnt
// Configuration macro: FRAME_SWAP_DROP_CNT_EN
//   defined   -> dropped_cnt is a saturating counter of dropped frames
//   undefined -> no counter logic, dropped_cnt tied to zero
// ----------------------------------------------------------------------------
module frame_swap_scheduler
    import video_pkg::*;
#(
    parameter int CE_DIV          = 4,
    parameter int FRAME_CNT_WIDTH = 16,
    parameter int DROP_CNT_WIDTH  = 8
) (
    input  logic                   clk_rgb,
    input  logic                   rst,
    frame_swap_scheduler_if.master bus
);

    logic ce;

    ce_divider #(.DIV(CE_DIV)) u_ce_divider (
        .clk_rgb (clk_rgb),
        .rst     (rst),
        .ce      (ce)
    );

    fs_state_t                  state_q, state_d;
    logic                       render_start_q, render_start_d;
    buf_idx_t                   display_buf_q, display_buf_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                       fe;

`ifdef FRAME_SWAP_DROP_CNT_EN
    logic                       drop_ev;
    logic [DROP_CNT_WIDTH-1:0]  dropped_cnt_q, dropped_cnt_d;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
        input logic [DROP_CNT_WIDTH-1:0] v
    );
        return (v == '1) ? v : v + DROP_CNT_WIDTH'(1);
    endfunction
`endif

    // The iterator holds swap for a whole ce period; only the ce cycle counts.
    assign fe = bus.swap && ce;

    always_comb begin
        state_d        = state_q;
        render_start_d = 1'b0;
        display_buf_d  = display_buf_q;
        frame_cnt_d    = frame_cnt_q;
`ifdef FRAME_SWAP_DROP_CNT_EN
        drop_ev        = 1'b0;
`endif
        case (state_q)
            FS_START: begin
                render_start_d = 1'b1;
                state_d        = FS_RENDER;
            end
            FS_RENDER: begin
                if (bus.render_done && fe) begin
                    display_buf_d = ~display_buf_q;
                    frame_cnt_d   = frame_cnt_q + FRAME_CNT_WIDTH'(1);
                    state_d       = FS_START;
                end else if (bus.render_done) begin
                    state_d = FS_READY;
                end else if (fe) begin
`ifdef FRAME_SWAP_DROP_CNT_EN
                    drop_ev = 1'b1;
`endif
                end
            end
            FS_READY: begin
                // A stray render_done here is a protocol error and is ignored.
                if (fe) begin
                    display_buf_d = ~display_buf_q;
                    frame_cnt_d   = frame_cnt_q + FRAME_CNT_WIDTH'(1);
                    state_d       = FS_START;
                end
            end
            default: state_d = FS_START;
        endcase
    end

    always_ff @(posedge clk_rgb) begin
        if (rst) begin
            state_q        <= FS_START;
            render_start_q <= 1'b0;
            display_buf_q  <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            render_start_q <= render_start_d;
            display_buf_q  <= display_buf_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

`ifdef FRAME_SWAP_DROP_CNT_EN
    always_comb begin
        dropped_cnt_d = drop_ev ? sat_inc(dropped_cnt_q) : dropped_cnt_q;
    end

    always_ff @(posedge clk_rgb) begin
        if (rst) begin
            dropped_cnt_q <= '0;
        end else begin
            dropped_cnt_q <= dropped_cnt_d;
        end
    end

    assign bus.dropped_cnt = dropped_cnt_q;
`else
    assign bus.dropped_cnt = '0;
`endif

    assign bus.ce           = ce;
    assign bus.render_start = render_start_q;
    assign bus.display_buf  = display_buf_q;
    assign bus.draw_buf     = ~display_buf_q;
    assign bus.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_frame_swap_scheduler.sv
// ----------------------------------------------------------------------------
// tb_frame_swap_scheduler
// Directed bench for frame_swap_scheduler with CE_DIV=4 and narrow counters
// (FRAME_CNT_WIDTH=2, DROP_CNT_WIDTH=2) so wrap and saturation are reachable.
// Cycle numbering: cycle 0 is the first cycle with rst low; ce is high in
// cycles 4, 8, 12, ... Inputs for cycle c are driven at the negedge inside
// cycle c and outputs of cycle c are sampled at that same negedge.
// ----------------------------------------------------------------------------
module tb_frame_swap_scheduler;

    localparam int FW = 2;
    localparam int DW = 2;

`ifdef FRAME_SWAP_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic clk_rgb = 1'b0;
    logic rst     = 1'b1;

    always #5 clk_rgb = ~clk_rgb;

    frame_swap_scheduler_if #(.FRAME_CNT_WIDTH(FW), .DROP_CNT_WIDTH(DW)) bus ();

    frame_swap_scheduler #(
        .CE_DIV          (4),
        .FRAME_CNT_WIDTH (FW),
        .DROP_CNT_WIDTH  (DW)
    ) dut (
        .clk_rgb (clk_rgb),
        .rst     (rst),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    int rs_cnt = 0;

    // Running count of render_start pulses since the last reset.
    always @(posedge clk_rgb) begin
        if (rst) rs_cnt = 0;
        else if (bus.render_start) rs_cnt = rs_cnt + 1;
    end

    // Expected dropped_cnt: the counter only exists when the macro is defined.
    function automatic int ed(input int v);
        return DROP_EN ? v : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ce"},    int'(bus.ce),           0);
        chk({tag, "_rs"},    int'(bus.render_start), 0);
        chk({tag, "_disp"},  int'(bus.display_buf),  0);
        chk({tag, "_draw"},  int'(bus.draw_buf),     1);
        chk({tag, "_fc"},    int'(bus.frame_cnt),    0);
        chk({tag, "_drop"},  int'(bus.dropped_cnt),  0);
    endtask

    // One row = one ce period (4 cycles) with swap held for the whole period,
    // render_done pulsed in period cycle rd_cyc (-1 = never). Expected values
    // are sampled in the first cycle after the period.
    typedef struct {
        logic sw;
        int   rd_cyc;
        int   disp;
        int   fc;
        int   drop;
        int   rs;
    } row_t;

    row_t rows [13];

    function automatic row_t mk(input logic sw, input int rd, input int disp,
                                input int fc, input int drop, input int rs);
        row_t r;
        r.sw = sw; r.rd_cyc = rd; r.disp = disp; r.fc = fc; r.drop = drop; r.rs = rs;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             sw  rd  disp fc drop      rs
        rows[0]  = mk(1,  3,  1,  1, ed(0), 1); // done with frame end: flip, no drop
        rows[1]  = mk(0,  0,  1,  1, ed(0), 2); // done during START: ignored
        rows[2]  = mk(1, -1,  1,  1, ed(1), 2); // late render: drop
        rows[3]  = mk(1, -1,  1,  1, ed(2), 2);
        rows[4]  = mk(1, -1,  1,  1, ed(3), 2);
        rows[5]  = mk(1, -1,  1,  1, ed(3), 2); // saturated
        rows[6]  = mk(1, -1,  1,  1, ed(3), 2); // fifth drop, still saturated
        rows[7]  = mk(0,  1,  1,  1, ed(3), 2); // done, no frame end: READY
        rows[8]  = mk(0,  2,  1,  1, ed(3), 2); // done in READY: ignored
        rows[9]  = mk(1, -1,  0,  2, ed(3), 2); // flip from READY
        rows[10] = mk(0, -1,  0,  2, ed(3), 3);
        rows[11] = mk(1,  3,  1,  3, ed(3), 3);
        rows[12] = mk(1,  3,  0,  0, ed(3), 4); // frame_cnt wraps

        bus.swap        = 1'b0;
        bus.render_done = 1'b0;

        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) @(negedge clk_rgb);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Cycle 0 onward: render_done at 2 (READY), swap held 5..12.
        // ce-qualified frame ends at 8 (flip from READY) and 12 (drop in RENDER).
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("seq_ce_c%0d", c),   int'(bus.ce), (c >= 4 && c % 4 == 0) ? 1 : 0);
            chk($sformatf("seq_rs_c%0d", c),   int'(bus.render_start), (c == 1 || c == 10) ? 1 : 0);
            chk($sformatf("seq_disp_c%0d", c), int'(bus.display_buf), (c >= 9) ? 1 : 0);
            chk($sformatf("seq_draw_c%0d", c), int'(bus.draw_buf), (c >= 9) ? 0 : 1);
            chk($sformatf("seq_fc_c%0d", c),   int'(bus.frame_cnt), (c >= 9) ? 1 : 0);
            chk($sformatf("seq_drop_c%0d", c), int'(bus.dropped_cnt), (c >= 13) ? ed(1) : 0);
            bus.swap        = (c >= 5 && c <= 12);
            bus.render_done = (c == 2);
            @(negedge clk_rgb);
        end

        // Reset while in RENDER clears everything.
        bus.swap        = 1'b0;
        bus.render_done = 1'b0;
        rst = 1'b1;
        @(negedge clk_rgb);
        chk_reset_vals("midrst");
        rst = 1'b0;
        @(negedge clk_rgb);
        chk("midrst_rs_c1", int'(bus.render_start), 1);

        // Table: starts in cycle 1 of the fresh post-reset sequence.
        for (int i = 0; i < 13; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (j > 0) @(negedge clk_rgb);
                bus.swap        = rows[i].sw;
                bus.render_done = (rows[i].rd_cyc == j);
            end
            @(negedge clk_rgb);
            bus.swap        = 1'b0;
            bus.render_done = 1'b0;
            chk($sformatf("row%0d_disp", i), int'(bus.display_buf), rows[i].disp);
            chk($sformatf("row%0d_draw", i), int'(bus.draw_buf),    1 - rows[i].disp);
            chk($sformatf("row%0d_fc", i),   int'(bus.frame_cnt),   rows[i].fc);
            chk($sformatf("row%0d_drop", i), int'(bus.dropped_cnt), rows[i].drop);
            chk($sformatf("row%0d_rscnt", i), rs_cnt,               rows[i].rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
